// File: rtl/sequencer.sv
// Multi-cycle control sequencer for the suro-v.2 core: fetch, operand read, execute,
// memory and writeback over a shared memory port and a multi-cycle ALU.
package seq_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Shared encoding for pc_src, maddr_src and rf_src.
  localparam logic [1:0] SRC_PC_PLUS4 = 2'd0;
  localparam logic [1:0] SRC_PC2      = 2'd1;
  localparam logic [1:0] SRC_ALU      = 2'd2;
  localparam logic [1:0] SRC_CNTR     = 2'd3;

  localparam logic SRC_RF  = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  localparam logic [1:0] RN_X0  = 2'd0;
  localparam logic [1:0] RN_RS1 = 2'd1;
  localparam logic [1:0] RN_RS2 = 2'd2;
  localparam logic [1:0] RN_RD  = 2'd3;

  typedef logic [6:0] opcode_t;

  typedef struct packed {
    logic       set_ir;
    logic       set_pc;
    logic       set_pc2;
    logic       set_r1;
    logic       set_r2;
    logic       start;
    logic       alu_a_r1;
    logic       alu_b_r2;
    logic       alu_op;
    logic       memop;
    logic [1:0] pc_src;
    logic [1:0] maddr_src;
    logic [1:0] rf_src;
    logic [1:0] rf_regnum_src;
    logic       r1_src;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);
endpackage

module sequencer
  import seq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic              done_i,
  input  logic              branch_taken_i,
  input  logic              mem_ack_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              rf_we_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic              halt_o
);

  typedef enum logic [3:0] {
    S_FETCH, S_RS1, S_RS2, S_EXEC, S_BTGT, S_MEM, S_LDADD, S_WB, S_HALT
  } state_e;

  state_e state_q, state_d;
  logic   redirect_q, redirect_d;
  logic   started_q, started_d;
  logic   active_q;
  ctrl_t  ctrl;
  logic   legal, is_jump;

  assign legal   = opcode_i inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                                    OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_SYSTEM};
  assign is_jump = (opcode_i == OP_JAL) || (opcode_i == OP_JALR);
  assign ctrl_o  = ctrl;

  // active_q holds every output at its default until the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_FETCH;
      redirect_q <= 1'b0;
      started_q  <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      redirect_q <= redirect_d;
      started_q  <= started_d;
      active_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d            = state_q;
    redirect_d         = redirect_q;
    started_d          = 1'b0;
    ctrl               = '0;
    ctrl.rf_regnum_src = RN_X0;
    ctrl.maddr_src     = SRC_PC_PLUS4;
    rf_we_o            = 1'b0;
    mem_req_o          = 1'b0;
    mem_we_o           = 1'b0;
    halt_o             = 1'b0;
    if (active_q) begin
      case (state_q)
        S_FETCH: begin
          mem_req_o      = 1'b1;
          ctrl.maddr_src = redirect_q ? SRC_PC2 : SRC_PC_PLUS4;
          ctrl.pc_src    = redirect_q ? SRC_PC2 : SRC_PC_PLUS4;
          if (mem_ack_i) begin
            ctrl.set_ir = 1'b1;
            ctrl.set_pc = 1'b1;
            redirect_d  = 1'b0;
            state_d     = S_RS1;
          end
        end
        S_RS1: begin
          ctrl.rf_regnum_src = (opcode_i == OP_LUI) ? RN_X0 : RN_RS1;
          ctrl.set_r1        = 1'b1;
          ctrl.r1_src        = SRC_RF;
          if (!legal) state_d = S_HALT;
          else begin
            case (opcode_i)
              OP_OP, OP_BRANCH, OP_STORE, OP_LOAD: state_d = S_RS2;
              OP_SYSTEM: state_d = (funct3_i == 3'd0) ? S_HALT : S_WB;
              default:   state_d = S_EXEC;
            endcase
          end
        end
        S_RS2: begin
          ctrl.set_r2        = 1'b1;
          ctrl.rf_regnum_src = (opcode_i == OP_LOAD) ? RN_X0 : RN_RS2;
          state_d            = S_EXEC;
        end
        S_EXEC: begin
          ctrl.start    = !started_q;
          started_d     = 1'b1;
          ctrl.alu_a_r1 = !((opcode_i == OP_AUIPC) || (opcode_i == OP_JAL));
          ctrl.alu_b_r2 = (opcode_i == OP_OP) || (opcode_i == OP_BRANCH);
          ctrl.alu_op   = (opcode_i == OP_OP) || (opcode_i == OP_IMM) || (opcode_i == OP_BRANCH);
          // done is only trusted from the cycle after start.
          if (started_q && done_i) begin
            started_d = 1'b0;
            if ((opcode_i == OP_LOAD) || (opcode_i == OP_STORE)) state_d = S_MEM;
            else if (is_jump) begin
              ctrl.set_pc2 = 1'b1;
              redirect_d   = 1'b1;
              state_d      = S_WB;
            end else if (opcode_i == OP_BRANCH) state_d = branch_taken_i ? S_BTGT : S_FETCH;
            else state_d = S_WB;
          end
        end
        S_BTGT: begin
          ctrl.start = !started_q;
          started_d  = 1'b1;
          if (started_q && done_i) begin
            started_d   = 1'b0;
            ctrl.set_pc = 1'b1;
            ctrl.pc_src = SRC_ALU;
            state_d     = S_FETCH;
          end
        end
        S_MEM: begin
          mem_req_o      = 1'b1;
          ctrl.memop     = 1'b1;
          ctrl.maddr_src = SRC_ALU;
          mem_we_o       = (opcode_i == OP_STORE);
          if (mem_ack_i) begin
            if (opcode_i == OP_STORE) state_d = S_FETCH;
            else begin
              ctrl.set_r1 = 1'b1;
              ctrl.r1_src = SRC_MEM;
              state_d     = S_LDADD;
            end
          end
        end
        S_LDADD: begin
          ctrl.alu_a_r1 = 1'b1;
          ctrl.alu_b_r2 = 1'b1;
          ctrl.start    = !started_q;
          started_d     = 1'b1;
          if (started_q && done_i) begin
            started_d = 1'b0;
            state_d   = S_WB;
          end
        end
        S_WB: begin
          ctrl.rf_regnum_src = RN_RD;
          rf_we_o            = 1'b1;
          ctrl.rf_src        = is_jump ? SRC_PC_PLUS4 :
                               (opcode_i == OP_SYSTEM) ? SRC_CNTR : SRC_ALU;
          state_d            = S_FETCH;
        end
        S_HALT:  halt_o = 1'b1;
        default: state_d = S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_sequencer.sv
// Bench for sequencer: directed and random instruction streams against a per-instruction
// cycle/strobe model, with a randomized-latency memory and ALU environment.
module tb_sequencer;
  import seq_pkg::*;

  logic clk_i, rst_ni, done_i, branch_taken_i, mem_ack_i;
  logic [6:0] opcode_i;
  logic [2:0] funct3_i;
  logic [CTRL_W-1:0] ctrl_w;
  logic rf_we_o, mem_req_o, mem_we_o, halt_o;
  ctrl_t c;
  assign c = ctrl_w;

  sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .done_i(done_i), .branch_taken_i(branch_taken_i), .mem_ack_i(mem_ack_i),
    .ctrl_o(ctrl_w), .rf_we_o(rf_we_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .halt_o(halt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_err = 0;
  int cyc = 0, alu_ready = 0, alu_lat = 1, data_wait = 0;
  int req_cyc = 0, req_wait = 0, fw_used = 0;
  bit pend = 0, zero_fetch = 1, exp_redirect = 0;
  logic [1:0] req_maddr = 2'd0;
  int last_first = 0, last_wb = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive memory/ALU responses after the edge, sample at the falling edge.
  task automatic cycle();
    bit had_pend;
    int viol;
    @(posedge clk_i); #1;
    cyc++;
    had_pend = pend;
    if (mem_req_o && !pend) begin
      pend      = 1;
      req_cyc   = cyc;
      req_maddr = c.maddr_src;
      req_wait  = c.memop ? data_wait : (zero_fetch ? 0 : int'($urandom_range(0, 2)));
      if (!c.memop) fw_used = req_wait;
    end
    mem_ack_i = pend && (cyc - req_cyc >= req_wait);
    done_i    = (cyc >= alu_ready);
    @(negedge clk_i);
    viol = 0;
    if (rf_we_o && mem_we_o) viol += 1;
    if (mem_req_o && !c.memop && (rf_we_o || mem_we_o)) viol += 2;
    if (had_pend && (!mem_req_o || c.maddr_src != req_maddr)) viol += 4;
    chk("invariant", viol, 0);
    if (c.start) alu_ready = cyc + alu_lat;
    if (mem_ack_i) pend = 0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    chk("reset_outputs", int'({ctrl_w, rf_we_o, mem_req_o, mem_we_o, halt_o}), 0);
    pend = 0; mem_ack_i = 1'b0;
    repeat (2) cycle();
    rst_ni = 1'b1;
    cyc = 0; alu_ready = 0; exp_redirect = 0;
    #1;
    chk("no_req_before_edge", int'(mem_req_o), 0);
    cycle();
    chk("first_req_cycle1", int'(mem_req_o && !c.memop), 1);
  endtask

  // Precondition: the currently sampled cycle is the first FETCH cycle of this instruction.
  // Returns with the first FETCH cycle of the following instruction sampled.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int lat,
                           input int dw, input bit bt);
    int n_cyc = 0, n_start = 0, n_rfwe = 0, n_memwe = 0, n_memop = 0, n_pcalu = 0, n_ldr1 = 0;
    int fw, guard, e_cyc, e_start, wb_at = 0;
    logic [1:0] rf_src_seen = 2'd0, fsrc, psrc, e_src;
    bit ld, st, br, jmp, sys, rs2, taken, wb, prev_fetch = 0, is_fetch;
    opcode_i = op; funct3_i = f3; branch_taken_i = bt; alu_lat = lat; data_wait = dw;
    fw = fw_used; fsrc = c.maddr_src; psrc = c.pc_src; last_first = cyc;
    for (guard = 0; guard < 300; guard++) begin
      if (guard > 0) cycle();
      is_fetch = mem_req_o && !c.memop;
      if (guard > 0 && is_fetch && !prev_fetch) break;
      prev_fetch = is_fetch;
      n_cyc++;
      if (c.start) n_start++;
      if (rf_we_o) begin n_rfwe++; rf_src_seen = c.rf_src; wb_at = cyc; end
      if (mem_we_o) n_memwe++;
      if (mem_req_o && c.memop) n_memop++;
      if (c.set_pc && c.pc_src == SRC_ALU) n_pcalu++;
      if (c.set_r1 && c.r1_src == SRC_MEM) n_ldr1++;
    end
    chk("timeout", int'(guard >= 300), 0);
    last_wb = wb_at;
    ld = op == OP_LOAD; st = op == OP_STORE; br = op == OP_BRANCH; sys = op == OP_SYSTEM;
    jmp = (op == OP_JAL) || (op == OP_JALR);
    rs2 = ld || st || br || op == OP_OP;
    taken = br && bt;
    wb = !(br || st);
    e_cyc = fw + 2 + int'(rs2) + (sys ? 0 : lat + 1) + ((ld || st) ? dw + 1 : 0)
          + ((ld || taken) ? lat + 1 : 0) + int'(wb);
    e_start = sys ? 0 : 1 + int'(ld || taken);
    e_src = jmp ? SRC_PC_PLUS4 : (sys ? SRC_CNTR : SRC_ALU);
    chk("fetch_src", int'({fsrc, psrc}), exp_redirect ? int'({SRC_PC2, SRC_PC2}) : 0);
    exp_redirect = jmp;
    chk("instr_cycles", n_cyc, e_cyc);
    chk("alu_starts", n_start, e_start);
    chk("rf_we_count", n_rfwe, int'(wb));
    chk("mem_cycles", n_memop * 100 + n_memwe, (ld || st) ? (dw + 1) * 100 + (st ? dw + 1 : 0) : 0);
    chk("pc_alu_ld_r1", n_pcalu * 10 + n_ldr1, int'(taken) * 10 + int'(ld));
    if (wb) chk("rf_src", int'(rf_src_seen), int'(e_src));
  endtask

  task automatic halt_test(input logic [6:0] op, input logic [2:0] f3);
    int ack_cyc = -1, halt_cyc = -1, bad = 0;
    opcode_i = op; funct3_i = f3;
    for (int g = 0; g < 30 && halt_cyc < 0; g++) begin
      if (g > 0) cycle();
      if (c.set_ir && ack_cyc < 0) ack_cyc = cyc;
      if (halt_o) halt_cyc = cyc;
    end
    chk("halt_latency", halt_cyc - ack_cyc, 2);
    for (int g = 0; g < 10; g++) begin
      cycle();
      if (!halt_o || mem_req_o || rf_we_o || mem_we_o || ctrl_w != '0) bad++;
    end
    chk("halt_hold", bad, 0);
  endtask

  logic [6:0] ops [10];

  initial begin
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_SYSTEM};
    opcode_i = OP_IMM; funct3_i = 3'd0; done_i = 1'b0; branch_taken_i = 1'b0; mem_ack_i = 1'b0;
    rst_ni = 1'b1;
    #1;
    do_reset();

    run_instr(OP_IMM, 3'd0, 1, 0, 0);
    chk("addi_wb_cycle", last_wb, 5);
    chk("addi_next_fetch", cyc * 10 + int'(mem_req_o) * 4 + int'(c.maddr_src), 61 * 1 + 3);
    run_instr(OP_OP, 3'd0, 1, 0, 0);
    run_instr(OP_BRANCH, 3'd0, 1, 0, 1);
    run_instr(OP_BRANCH, 3'd0, 1, 0, 0);
    run_instr(OP_JAL, 3'd0, 1, 0, 0);
    run_instr(OP_IMM, 3'd0, 1, 0, 0);
    run_instr(OP_IMM, 3'd0, 2, 0, 0);
    run_instr(OP_LOAD, 3'd2, 1, 3, 0);
    run_instr(OP_STORE, 3'd2, 1, 3, 0);
    run_instr(OP_JALR, 3'd0, 3, 0, 0);
    run_instr(OP_LUI, 3'd0, 1, 0, 0);
    run_instr(OP_SYSTEM, 3'd2, 1, 0, 0);
    run_instr(OP_AUIPC, 3'd0, 2, 0, 0);

    zero_fetch = 0;
    for (int i = 0; i < 40; i++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, 9)];
      run_instr(op, (op == OP_SYSTEM) ? 3'($urandom_range(1, 7)) : 3'($urandom_range(0, 7)),
                $urandom_range(1, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    zero_fetch = 1;

    // Reset while a load is waiting in MEM.
    opcode_i = OP_LOAD; alu_lat = 1; data_wait = 20;
    begin
      int g;
      for (g = 0; g < 50 && !(mem_req_o && c.memop); g++) cycle();
      chk("reached_mem", int'(mem_req_o && c.memop), 1);
    end
    #2;
    do_reset();
    run_instr(OP_IMM, 3'd0, 1, 0, 0);
    chk("post_reset_wb_cycle", last_wb, 5);

    halt_test(7'h7F, 3'd0);
    do_reset();
    halt_test(OP_SYSTEM, 3'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
